// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; the core stalls while o_busy is high.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  dvd, dsr, quo;
  logic             rem_op, neg_q, neg_r;

  // Request decode: op[0] clear means signed, op[1] set means remainder.
  logic            is_signed, want_rem, div_zero, overflow, special;
  logic [XLEN-1:0] rs1_mag, rs2_mag, special_result;

  assign is_signed = ~i_op[0];
  assign want_rem  = i_op[1];
  assign div_zero  = (i_rs2_data == '0);
  assign overflow  = is_signed && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (i_rs2_data == '1);
  assign special   = div_zero || overflow;

  // Negating the most negative value wraps to itself, which is the correct
  // unsigned magnitude, so no overflow handling is needed here.
  assign rs1_mag = (is_signed && i_rs1_data[XLEN-1]) ? -i_rs1_data : i_rs1_data;
  assign rs2_mag = (is_signed && i_rs2_data[XLEN-1]) ? -i_rs2_data : i_rs2_data;

  assign special_result = div_zero ? (want_rem ? i_rs1_data : '1)
                                   : (want_rem ? '0 : i_rs1_data);

  // One restoring step: shift the next dividend bit in and try to subtract.
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            trial_ok;
  logic [XLEN-1:0] rem_mag;

  assign rem_shift = {rem[XLEN-1:0], dvd[XLEN-1]};
  assign trial_ok  = (rem_shift >= {1'b0, dsr});
  assign rem_diff  = rem_shift - {1'b0, dsr};
  assign rem_mag   = XLEN'(rem);

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so that
  // paths which do not assign it cannot infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = special ? DONE : CALC;
      CALC:    if (count == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count     <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      quo       <= '0;
      rem_op    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          rem_op    <= want_rem;
          neg_q     <= is_signed && (i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]);
          neg_r     <= is_signed && i_rs1_data[XLEN-1];
          dvd       <= rs1_mag;
          dsr       <= rs2_mag;
          rem       <= '0;
          quo       <= '0;
          count     <= CNT_W'(XLEN-1);
          o_rd_addr <= i_rd_addr;
          if (special) o_result <= special_result;
        end
        CALC: begin
          rem   <= trial_ok ? rem_diff : rem_shift;
          quo   <= {quo[XLEN-2:0], trial_ok};
          dvd   <= dvd << 1;
          count <= count - CNT_W'(1);
        end
        FIX: begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          if (rem_op) o_result <= neg_r ? -rem_mag : rem_mag;
          else        o_result <= neg_q ? -quo : quo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a scoreboard queue holds expected result,
// destination and completion cycle for every accepted request.
module tb_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        i_clk, i_reset, i_start;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy, o_done;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  div_unit #(.XLEN(32)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: every o_done pulse must match the oldest outstanding request.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(o_done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("rd_addr", 32'(o_rd_addr), 32'(e.rd));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Reference model built on the simulator's own signed/unsigned arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic [31:0] q, r;
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    res = op[1] ? r : q;
  endfunction

  // Called away from the clock edge; the accept edge is the next posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
    sb.push_back('{exp_res, rd, cyc + lat});
    i_start = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
    @(posedge i_clk); #1;
    i_start    = 1'b0;
    i_op       = 2'($urandom);
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
    i_rd_addr  = 5'($urandom);
    check("busy_after_accept", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || sb.size() != 0) && n < 100) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (o_busy || sb.size() != 0) begin
      check("timeout_pending", 32'(sb.size()) + 32'(o_busy), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
    issue(op, a, b, rd, exp_res, lat);
    wait_idle();
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          n;
    logic [1:0]  op;
    logic [31:0] a, b;

    i_reset = 1'b1; i_start = 1'b0; i_op = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_rd_addr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_result", o_result, 32'd0);
    check("reset_rd", 32'(o_rd_addr), 32'd0);
    @(negedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk); #1;

    // Directed cases with hand-derived results.
    run(OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         34);
    run(OP_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          34);
    run(OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  34);
    run(OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  34);
    run(OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFD,  34);
    run(OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          34);
    run(OP_DIVU, 32'h1234_5678,  32'd0,          5'd5,  32'hFFFF_FFFF,  1);
    run(OP_REMU, 32'h1234_5678,  32'd0,          5'd5,  32'h1234_5678,  1);
    run(OP_DIV,  32'h1234_5678,  32'd0,          5'd8,  32'hFFFF_FFFF,  1);
    run(OP_REM,  32'hF000_0000,  32'd0,          5'd9,  32'hF000_0000,  1);
    run(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1);
    run(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1);
    run(OP_DIVU, 32'h8000_0000,  32'd1,          5'd12, 32'h8000_0000,  34);
    run(OP_DIV,  32'h8000_0000,  32'd2,          5'd13, 32'hC000_0000,  34);
    run(OP_REMU, 32'd5,          32'd9,          5'd14, 32'd5,          34);
    run(OP_DIVU, 32'd5,          32'd9,          5'd0,  32'd0,          34);
    run(OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  5'd31, 32'd1,          34);

    // Starts during CALC and DONE must be ignored; accept right after DONE.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    repeat (5) @(negedge i_clk);
    #1;
    i_start = 1'b1; i_op = OP_DIV; i_rs1_data = 32'd55; i_rs2_data = 32'd5; i_rd_addr = 5'd9;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 0;
    while (!o_done && n < 60) begin
      @(negedge i_clk); #1;
      n++;
    end
    check("wait_first_done", 32'(o_done), 32'd1);
    check("busy_in_done", 32'(o_busy), 32'd1);
    i_start = 1'b1; i_op = OP_DIV; i_rs1_data = 32'd55; i_rs2_data = 32'd5; i_rd_addr = 5'd9;
    @(negedge i_clk); #1;
    check("idle_after_done", 32'(o_busy), 32'd0);
    run(OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 34);

    // Reset mid-operation aborts without a done pulse.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd7, 32'd333, 34);
    repeat (8) @(negedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_result", o_result, 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_rd", 32'(o_rd_addr), 32'd0);
    sb.delete();
    @(negedge i_clk); #1;
    i_reset = 1'b0;
    repeat (40) @(negedge i_clk);
    #1;
    run(OP_DIVU, 32'd9, 32'd3, 5'd15, 32'd3, 34);

    // Randomised operands against the reference model, with biased corner values.
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      model(op, a, b, res, lat);
      run(op, a, b, 5'($urandom), res, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
